task_stream_buffer: RTL and testbench

- Parametrised task FIFO between the task producer and the downstream compute engine.
- Successor to the fixed 20-entry, 4-cycle-per-task input buffer.
- Decouples producer bursts from consumer backpressure.
- Full valid/ready handshake on both sides, throughput of one task per cycle.
- Configurable storage read latency; occupancy and almost-full flags; sticky overflow flag.

---
 rtl/task_stream_buffer.sv | 122 ++++++++++++
 tb/tb_task_stream_buffer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/task_stream_buffer.sv
// Task FIFO between the task producer and the compute engine: block storage with
// a pipelined read path feeding a small registered staging queue at the output.
module task_stream_buffer #(
  parameter int TASK_SIZE    = 144,
  parameter int DEPTH        = 32,
  parameter int READ_LATENCY = 2,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  output logic                     ready_out,
  input  logic [TASK_SIZE-1:0]     data_in,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [TASK_SIZE-1:0]     data_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     overflow
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int STG = READ_LATENCY + 1;
  localparam int SKW = $clog2(READ_LATENCY + 1);

  logic [TASK_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        st_cnt, cnt_next;

  logic [READ_LATENCY-1:0] vld_p;
  logic [TASK_SIZE-1:0]    data_p [READ_LATENCY];

  // Skid entries sit behind the data_out register; together they form the staging queue.
  logic [TASK_SIZE-1:0] skid [READ_LATENCY];
  logic [SKW-1:0]       skid_cnt, push_idx;

  logic       wr_acc, xfer, rd_issue, arrive;
  logic       out_load, out_from_skid, skid_pop, skid_push;
  logic [3:0] inflight, occ;

  assign ready_out = ~full;
  assign wr_acc    = valid_in & ~full;
  assign xfer      = valid_out & ready_in;
  assign arrive    = vld_p[READ_LATENCY-1];
  assign cnt_next  = count + CW'(wr_acc) - CW'(xfer);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + 4'(vld_p[i]);
    occ = 4'(valid_out) + 4'(skid_cnt) + inflight;
    // A transfer this cycle frees a slot, so a read can issue without a bubble.
    rd_issue = (st_cnt != '0) && (occ < 4'(STG) + 4'(xfer));

    out_load      = 1'b0;
    out_from_skid = 1'b0;
    if (!valid_out || xfer) begin
      if (skid_cnt != '0) begin
        out_load      = 1'b1;
        out_from_skid = 1'b1;
      end else if (arrive) begin
        out_load = 1'b1;
      end
    end
    skid_pop  = out_load & out_from_skid;
    skid_push = arrive & ~(out_load & ~out_from_skid);
    push_idx  = skid_cnt - SKW'(skid_pop);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  // Read pipeline: stage 0 is the registered storage read.
  always_ff @(posedge clk) begin
    if (rd_issue) data_p[0] <= mem[rd_ptr];
    for (int i = 1; i < READ_LATENCY; i++) data_p[i] <= data_p[i-1];
  end

  always_ff @(posedge clk) begin
    if (skid_pop)
      for (int i = 0; i < READ_LATENCY - 1; i++) skid[i] <= skid[i+1];
    if (skid_push) skid[push_idx] <= data_p[READ_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      st_cnt      <= '0;
      vld_p       <= '0;
      skid_cnt    <= '0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_acc);
      rd_ptr <= rd_ptr + AW'(rd_issue);
      st_cnt <= st_cnt + CW'(wr_acc) - CW'(rd_issue);
      vld_p[0] <= rd_issue;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
      skid_cnt <= skid_cnt + SKW'(skid_push) - SKW'(skid_pop);
      // Output stage: data_out keeps its last value when nothing new loads.
      if (out_load) begin
        valid_out <= 1'b1;
        data_out  <= out_from_skid ? skid[0] : data_p[READ_LATENCY-1];
      end else if (xfer) begin
        valid_out <= 1'b0;
      end
      count       <= cnt_next;
      empty       <= (cnt_next == '0);
      full        <= (cnt_next == CW'(DEPTH));
      almost_full <= (cnt_next >= CW'(AFULL_THRESH));
      if (valid_in && full) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_task_stream_buffer.sv
// Directed and random stimulus for task_stream_buffer, checked every cycle against a
// queue model that knows only acceptance, FIFO order and fixed write-to-output latency.
module tb_task_stream_buffer;
  localparam int TW    = 144;
  localparam int DEPTH = 8;
  localparam int RL    = 2;
  localparam int AFT   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_in = 1'b0;
  logic [TW-1:0] data_in = '0;
  logic          ready_out, valid_out, empty, full, almost_full, overflow;
  logic [TW-1:0] data_out;
  logic [CW-1:0] count;

  task_stream_buffer #(.TASK_SIZE(TW), .DEPTH(DEPTH), .READ_LATENCY(RL),
                       .AFULL_THRESH(AFT)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .data_in(data_in), .valid_out(valid_out), .ready_in(ready_in),
    .data_out(data_out), .count(count), .empty(empty), .full(full),
    .almost_full(almost_full), .overflow(overflow));

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] d;
    int            t;
  } ent_t;

  ent_t          q[$];
  int            n = 0;
  int            checks = 0;
  int            errors = 0;
  int            max_cnt = 0;
  logic          ovf = 1'b0;
  logic [TW-1:0] last_d = '0;

  // The head is visible READ_LATENCY+1 edges after the edge that accepted it.
  function automatic logic mvld();
    return (q.size() > 0) && (q[0].t + RL + 1 <= n);
  endfunction

  function automatic logic [TW-1:0] rnd();
    logic [TW-1:0] r = '0;
    for (int i = 0; i < 5; i++) r = (r << 32) | TW'($urandom());
    return r;
  endfunction

  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, n, obs, exp);
    end
  endtask

  task automatic check_all();
    logic          v = mvld();
    logic [TW-1:0] ed = v ? q[0].d : last_d;
    chk("count", TW'(count), TW'(q.size()));
    chk("empty", TW'(empty), TW'(q.size() == 0));
    chk("full", TW'(full), TW'(q.size() == DEPTH));
    chk("almost_full", TW'(almost_full), TW'(q.size() >= AFT));
    chk("ready_out", TW'(ready_out), TW'(q.size() != DEPTH));
    chk("overflow", TW'(overflow), TW'(ovf));
    chk("valid_out", TW'(valid_out), TW'(v));
    chk("data_out", data_out, ed);
    if (q.size() > max_cnt) max_cnt = q.size();
  endtask

  task automatic step(input logic r, input logic vi, input logic [TW-1:0] di, input logic ri);
    logic acc, xf;
    rst = r; valid_in = vi; data_in = di; ready_in = ri;
    acc = !r && vi && (q.size() < DEPTH);
    xf  = !r && ri && mvld();
    @(posedge clk);
    n++;
    if (r) begin
      q.delete();
      ovf    = 1'b0;
      last_d = '0;
    end else begin
      if (vi && q.size() == DEPTH) ovf = 1'b1;
      if (xf) begin
        last_d = q[0].d;
        void'(q.pop_front());
      end
      if (acc) q.push_back('{di, n});
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int k, input logic ri);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, '0, ri);
  endtask

  initial begin
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);

    // Single task through an empty buffer.
    idle(7, 1'b1);
    step(1'b0, 1'b1, TW'('hA5), 1'b1);
    idle(6, 1'b1);

    // Fill past capacity with the consumer stalled, then drain.
    for (int i = 1; i <= 10; i++) step(1'b0, 1'b1, TW'(i), 1'b0);
    idle(3, 1'b0);
    idle(12, 1'b1);

    // Continuous stream with the consumer always ready.
    max_cnt = 0;
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, TW'(i), 1'b1);
    idle(6, 1'b1);
    chk("stream_max_count", TW'(max_cnt <= 4), TW'(1));

    // At full: simultaneous transfer and write; the write is refused, the next accepted.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, TW'('h100 + i), 1'b0);
    idle(2, 1'b0);
    step(1'b0, 1'b1, TW'('h55), 1'b1);
    step(1'b0, 1'b1, TW'('h66), 1'b0);
    idle(14, 1'b1);

    // Random traffic.
    for (int i = 0; i < 2000; i++)
      step(1'b0, 1'($urandom_range(0, 1)), rnd(), 1'($urandom_range(0, 1)));
    idle(14, 1'b1);

    // Reset with tasks queued and reads in flight.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, TW'('h200 + i), 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, TW'('h77), 1'b1);
    idle(6, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
